// File: rtl/scalable_cu_pkg.sv
// Shared types and default widths for the scalable compute unit.
// Mode encoding and the S1 payload bundle live here.
package scalable_cu_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int RESULT_W_DEF = 32;
  localparam int NUM_CH_DEF   = 4;
  localparam int CH_W_DEF     = 2;
  localparam int SHIFT_W_DEF  = 5;

  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_ACCUM = 1'b1
  } mode_e;

  // S1 payload at default widths
  typedef struct packed {
    logic [RESULT_W_DEF-1:0] sh;
    logic [CH_W_DEF-1:0]     ch;
    mode_e                   mode;
  } s1_t;

endpackage

// File: rtl/scalable_compute_unit_acc_bank.sv
// Per-channel accumulator bank: clear, add, carry-out.
// Saturation instead of wrap when SCALABLE_CU_SAT_EN is defined.
module cu_acc_bank
  import scalable_cu_pkg::*;
#(
  parameter int RESULT_W = RESULT_W_DEF,
  parameter int CH_W     = CH_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [CH_W-1:0]     ch,
  input  logic [RESULT_W-1:0] addend,
  output logic [RESULT_W-1:0] result,
  output logic                ovf
);

  localparam int DEPTH = 1 << CH_W;

  logic [RESULT_W-1:0] acc [DEPTH];
  logic [RESULT_W-1:0] base;
  logic [RESULT_W:0]   sum;

  // Clear wins over the old value, so a same-edge add starts from 0
  always_comb begin
    base   = clr ? '0 : acc[ch];
    sum    = {1'b0, base} + {1'b0, addend};
    ovf    = sum[RESULT_W];
    result = sum[RESULT_W-1:0];
`ifdef SCALABLE_CU_SAT_EN
    if (sum[RESULT_W]) result = '1;
`endif
  end

  // Clear all, then the selected channel takes the new total
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
      end
      if (en) acc[ch] <= result;
    end
  end

endmodule

// File: rtl/scalable_compute_unit.sv
// Multi-channel shift / accumulate unit, 2-stage valid/ready pipe.
// Option: SCALABLE_CU_SAT_EN selects saturating accumulation.
module scalable_compute_unit
  import scalable_cu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESULT_W = RESULT_W_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int CH_W     = CH_W_DEF,
  parameter int SHIFT_W  = SHIFT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [SHIFT_W-1:0]  in_shift,
  input  logic                in_mode,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_result,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_ovf
);

  typedef struct packed {
    logic [RESULT_W-1:0] sh;
    logic [CH_W-1:0]     ch;
    mode_e               mode;
  } pl_t;

  logic                s1_valid;
  pl_t                 s1_q;
  logic                s1_en;
  logic                s2_en;
  logic [RESULT_W-1:0] in_wide;
  logic [RESULT_W-1:0] in_sh;
  logic                ch_ok;
  logic                acc_en;
  logic [RESULT_W-1:0] acc_res;
  logic                acc_ovf;
  mode_e               in_mode_e;

  assign s2_en     = !out_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign in_mode_e = mode_e'(in_mode);
  assign in_wide   = RESULT_W'(in_data);
  assign ch_ok     = 32'(in_ch) < 32'(NUM_CH);

  // Left shift; oversize shift amounts give 0
  always_comb begin
    in_sh = '0;
    if (32'(in_shift) < 32'(RESULT_W)) in_sh = in_wide << in_shift;
  end

  // S1 register; out-of-range tags are accepted but not kept
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid && ch_ok;
      if (in_valid) s1_q <= '{sh: in_sh, ch: in_ch, mode: in_mode_e};
    end
  end

  assign acc_en = s1_valid && s2_en && (s1_q.mode == MODE_ACCUM);

  cu_acc_bank #(
    .RESULT_W (RESULT_W),
    .CH_W     (CH_W)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .en     (acc_en),
    .ch     (s1_q.ch),
    .addend (s1_q.sh),
    .result (acc_res),
    .ovf    (acc_ovf)
  );

  // Output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ch     <= '0;
      out_ovf    <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch <= s1_q.ch;
        if (s1_q.mode == MODE_ACCUM) begin
          out_result <= acc_res;
          out_ovf    <= acc_ovf;
        end else begin
          out_result <= s1_q.sh;
          out_ovf    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scalable_compute_unit.sv
// Directed bench for scalable_compute_unit.
// Expected results are hand-computed constants fed to a FIFO scoreboard.
module tb_scalable_compute_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_ch;
  logic [4:0]  in_shift;
  logic        in_mode;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_ch;
  logic        out_ovf;

  int n_assert;
  int n_fail;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  c;
    logic        o;
  } exp_t;

  exp_t q[$];

  scalable_compute_unit #(
    .DATA_W   (16),
    .RESULT_W (32),
    .NUM_CH   (4),
    .CH_W     (3),
    .SHIFT_W  (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ch      (in_ch),
    .in_shift   (in_shift),
    .in_mode    (in_mode),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ch     (out_ch),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] r, input logic [2:0] c,
                            input logic o);
    exp_t e;
    e.r = r;
    e.c = c;
    e.o = o;
    q.push_back(e);
  endtask

  task automatic xfer(input logic [15:0] d, input logic [2:0] c,
                      input logic [4:0] s, input logic m);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_ch    = c;
    in_shift = s;
    in_mode  = m;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("xfer_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 0);
  endtask

  // Scoreboard: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", 64'(out_result), 64'(e.r));
        check("ch", 64'(out_ch), 64'(e.c));
        check("ovf", 64'(out_ovf), 64'(e.o));
      end
    end
  end

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ch     = '0;
    in_shift  = '0;
    in_mode   = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_result", 64'(out_result), 0);
    check("rst_out_ch", 64'(out_ch), 0);
    check("rst_out_ovf", 64'(out_ovf), 0);
    check("rst_in_ready", 64'(in_ready), 1);

    // 1: SHIFT 3<<2 on ch1
    expect_out(32'h0000_000C, 3'd1, 1'b0);
    xfer(16'h0003, 3'd1, 5'd2, 1'b0);
    check("lat_s1_only", 64'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_out_valid", 64'(out_valid), 1);
    check("lat_out_result", 64'(out_result), 64'h0000_000C);
    drain();
    expect_out(32'h8000_0000, 3'd1, 1'b0);
    xfer(16'h0003, 3'd1, 5'd31, 1'b0);
    expect_out(32'hFFFF_0000, 3'd0, 1'b0);
    xfer(16'hFFFF, 3'd0, 5'd16, 1'b0);
    drain();

    // 2: back-to-back ACCUM on ch0, then SHIFT leaves acc0 alone
    expect_out(32'd5, 3'd0, 1'b0);
    expect_out(32'd12, 3'd0, 1'b0);
    expect_out(32'd1, 3'd0, 1'b0);
    expect_out(32'd12, 3'd0, 1'b0);
    xfer(16'd5, 3'd0, 5'd0, 1'b1);
    xfer(16'd7, 3'd0, 5'd0, 1'b1);
    xfer(16'd1, 3'd0, 5'd0, 1'b0);
    xfer(16'd0, 3'd0, 5'd0, 1'b1);
    drain();

    // 3: stall with a 4-sample stream
    expect_out(32'h110, 3'd2, 1'b0);
    expect_out(32'h120, 3'd2, 1'b0);
    expect_out(32'h130, 3'd2, 1'b0);
    expect_out(32'h140, 3'd2, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h11;
    in_ch     = 3'd2;
    in_shift  = 5'd4;
    in_mode   = 1'b0;
    @(posedge clk);
    #1;
    in_data = 16'h12;
    @(posedge clk);
    #1;
    check("stall_in_ready", 64'(in_ready), 0);
    check("stall_hold", 64'(out_result), 64'h110);
    in_data = 16'h13;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("stall_hold_res", 64'(out_result), 64'h110);
      check("stall_hold_valid", 64'(out_valid), 1);
      check("stall_in_ready_lo", 64'(in_ready), 0);
    end
    out_ready = 1'b1;
    xfer(16'h13, 3'd2, 5'd4, 1'b0);
    xfer(16'h14, 3'd2, 5'd4, 1'b0);
    drain();

    // 4: overflow on ch2
    expect_out(32'hFFFF_0000, 3'd2, 1'b0);
    expect_out(32'hFFFF_FFF0, 3'd2, 1'b0);
`ifdef SCALABLE_CU_SAT_EN
    expect_out(32'hFFFF_FFFF, 3'd2, 1'b1);
    expect_out(32'hFFFF_FFFF, 3'd2, 1'b0);
`else
    expect_out(32'h0000_0010, 3'd2, 1'b1);
    expect_out(32'h0000_0010, 3'd2, 1'b0);
`endif
    xfer(16'hFFFF, 3'd2, 5'd16, 1'b1);
    xfer(16'hFFF0, 3'd2, 5'd0, 1'b1);
    xfer(16'h0020, 3'd2, 5'd0, 1'b1);
    xfer(16'h0000, 3'd2, 5'd0, 1'b1);
    drain();

    // 5: clear on the edge the ch3 ACCUM of 9 enters S2
    expect_out(32'd100, 3'd3, 1'b0);
    expect_out(32'd9, 3'd3, 1'b0);
    xfer(16'd100, 3'd3, 5'd0, 1'b1);
    xfer(16'd9, 3'd3, 5'd0, 1'b1);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    expect_out(32'd0, 3'd0, 1'b0);
    expect_out(32'd0, 3'd1, 1'b0);
    expect_out(32'd0, 3'd2, 1'b0);
    expect_out(32'd9, 3'd3, 1'b0);
    for (int c = 0; c < 4; c++) xfer(16'd0, 3'(c), 5'd0, 1'b1);
    drain();

    // 6: reset with two samples in flight, then an out-of-range tag
    out_ready = 1'b0;
    xfer(16'd50, 3'd1, 5'd0, 1'b1);
    xfer(16'd60, 3'd1, 5'd0, 1'b1);
    check("inflight_valid", 64'(out_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_in_ready", 64'(in_ready), 1);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_no_out", 64'(out_valid), 0);
    for (int c = 0; c < 4; c++) expect_out(32'd0, 3'(c), 1'b0);
    for (int c = 0; c < 4; c++) xfer(16'd0, 3'(c), 5'd0, 1'b1);
    drain();
    xfer(16'd7, 3'd5, 5'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("badch_no_out", 64'(out_valid), 0);
    expect_out(32'd0, 3'd1, 1'b0);
    xfer(16'd0, 3'd1, 5'd0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
